// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator: register map, FSM
// encoding and the default largest n whose factorial fits in 32 bits.
package fact_pkg;

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // 12! = 0x1C8CFC00 is the last factorial below 2^32.
  localparam int N_MAX_DEFAULT = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

endpackage

// File: rtl/fact_ctrl.sv
// Control for the factorial accelerator: IDLE/CALC sequencing, the
// busy/done/err flags and the enables that steer the datapath registers.
module fact_ctrl
  import fact_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,          // qualified GO write with wd[0]=1
  input  logic n_over,      // N exceeds N_MAX
  input  logic cnt_gt1,     // another multiply step remains
  output logic busy,
  output logic done,
  output logic err,
  output logic load_en,     // cnt <= N, prod <= 1
  output logic step_en,     // prod <= prod*cnt, cnt <= cnt-1
  output logic capture_en   // RESULT <= prod
);

  state_t state_q;
  state_t state_d;
  logic   go_accept;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    go_accept  = 1'b0;
    load_en    = 1'b0;
    step_en    = 1'b0;
    capture_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          go_accept = 1'b1;
          if (!n_over) begin
            load_en = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        // GO writes are deliberately not looked at here.
        if (cnt_gt1) begin
          step_en = 1'b1;
        end else begin
          capture_en = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky status flags: cleared by an accepted GO, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else if (go_accept) begin
      done <= 1'b0;
      err  <= n_over;
    end else if (capture_en) begin
      done <= 1'b1;
    end
  end

  assign busy = (state_q == ST_CALC);

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator. Software writes N, pulses GO and
// polls STATUS; the result is produced by one 32x4 multiply per cycle,
// counting cnt down from N to 1.
module fact_accel
  import fact_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam logic [31:0] N_MAX_W = N_MAX;

  logic [3:0]  n_q;
  logic [3:0]  cnt;
  logic [31:0] prod;
  logic [31:0] result;
  logic [35:0] mul_full;

  logic busy;
  logic done;
  logic err;
  logic load_en;
  logic step_en;
  logic capture_en;
  logic go;
  logic n_over;
  logic cnt_gt1;
  logic unused_bits;

  assign go      = we && (a == ADDR_GO) && wd[0];
  assign n_over  = ({28'd0, n_q} > N_MAX_W);
  assign cnt_gt1 = (cnt > 4'd1);

  // Single combinational 32x4 multiply; only the low 32 bits are kept.
  assign mul_full = {4'd0, prod} * {32'd0, cnt};

  assign unused_bits = ^{wd[31:4], mul_full[35:32]};

  fact_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .n_over     (n_over),
    .cnt_gt1    (cnt_gt1),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_en    (load_en),
    .step_en    (step_en),
    .capture_en (capture_en)
  );

  // Datapath registers: N (software-owned), the working cnt/prod pair and RESULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every datapath register is reset, since software can observe
      // RESULT and N right after reset and a mid-run abort must leave RESULT=0.
      n_q    <= 4'd0;
      cnt    <= 4'd0;
      prod   <= 32'd0;
      result <= 32'd0;
    end else begin
      // N may be rewritten at any time; the running job works on its copy in cnt.
      if (we && (a == ADDR_N)) begin
        n_q <= wd[3:0];
      end
      if (load_en) begin
        cnt  <= n_q;
        prod <= 32'd1;
      end else if (step_en) begin
        cnt  <= cnt - 4'd1;
        prod <= mul_full[31:0];
      end
      if (capture_en) begin
        result <= prod;
      end
    end
  end

  // Zero-latency read mux; unused bits read as 0.
  always_comb begin
    rd = 32'd0;
    unique case (a)
      ADDR_N:      rd = {28'd0, n_q};
      ADDR_GO:     rd = {31'd0, busy};
      ADDR_STATUS: rd = {30'd0, err, done};
      ADDR_RESULT: rd = result;
      default:     rd = 32'd0;
    endcase
  end

endmodule

// File: doc/fact_accel.md
FACT_ACCEL -- requirements
Module: fact_accel

Interface
REQ-001 SHALL use parameter N_MAX, default 12, meaning the largest n whose factorial fits in 32 bits.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-004 SHALL have port a, input, 2, register word address from the processor's ALU result.
REQ-005 SHALL have port we, input, 1, write enable, already qualified by the system address decode.
REQ-006 SHALL have port wd, input, 32, write data from the processor's data-memory write port.
REQ-007 SHALL have port rd, output, 32, read data to the processor's data-memory read mux.

Function
REQ-008 SHALL decode this register map:
- a=0: N, read/write, bits [3:0].
- a=1: GO, write-only trigger; reads {31'b0, busy}.
- a=2: STATUS, read-only {30'b0, err, done}.
- a=3: RESULT, read-only, 32 bits.
REQ-009 SHALL drive rd combinationally from a with zero added latency; unused bits read 0.
REQ-010 SHALL, on we with a=0, load N <= wd[3:0] at the clock edge in any state; an in-flight computation is unaffected.
REQ-011 SHALL implement FSM states IDLE and CALC; busy is 1 exactly in CALC.
REQ-012 SHALL, on a write to GO with wd[0]=1 in IDLE (edge E0), clear done and err and then act on N:
- If N > N_MAX: set err=1, remain IDLE, leave RESULT unchanged.
- Otherwise: load cnt <= N and prod <= 1, and go to CALC.
REQ-013 SHALL ignore writes to GO with wd[0]=0, and ignore any GO write while in CALC.
REQ-014 SHALL perform one step per edge in CALC:
- If cnt > 1: prod <= prod*cnt (low 32 bits) and cnt <= cnt-1.
- Otherwise: RESULT <= prod, done <= 1, return to IDLE.
REQ-015 SHALL therefore assert done, with RESULT valid, after edge E0+max(N,1); N=0 and N=1 both yield RESULT=1 at E0+1.
REQ-016 SHALL hold RESULT, done and err stable in IDLE until the next accepted GO or reset; RESULT SHALL NOT change during CALC.
REQ-017 SHALL ignore writes to a=2 and a=3.

Reset
REQ-018 SHALL, on rst assertion and regardless of clk, force: state=IDLE, N=0, cnt=0, prod=0, RESULT=0, done=0, err=0.
REQ-019 SHALL abort any in-flight computation when reset is asserted mid-CALC, with no done pulse and RESULT=0 afterwards.
REQ-020 SHALL, after reset deassertion, accept a GO on the first clock edge.

Structure
REQ-021 SHALL place in a shared package:
- register address constants ADDR_N, ADDR_GO, ADDR_STATUS, ADDR_RESULT;
- FSM state encoding;
- N_MAX default.
REQ-022 SHALL split into a control sub-module fact_ctrl (FSM; busy/done/err; the load, decrement and capture enables) and top-level datapath registers, multiplier and read mux.
REQ-023 SHALL use a single 32x4-bit combinational multiply per cycle, with no multi-cycle multiplier.

Verification
REQ-024 SHALL cover: write N=5, GO=1 -> busy=1 for edges E1..E4; at E5 done=1, RESULT=0x00000078, busy=0.
REQ-025 SHALL cover: N=0, GO=1 -> at E1 done=1, RESULT=1; repeat with N=1 -> same.
REQ-026 SHALL cover: N=12, GO=1 -> at E12 RESULT=0x1C8CFC00, err=0.
REQ-027 SHALL cover: after the N=12 run, N=13, GO=1 -> err=1, done=0, busy=0, RESULT stays 0x1C8CFC00.
REQ-028 SHALL cover: N=5, GO=1, then at E2 write N=3 and GO=1 -> both ignored for the run; RESULT=120 at E5; N reads 3.
REQ-029 SHALL cover: N=7, GO=1, assert rst between clock edges at E3 -> immediately state IDLE, RESULT=0, done=0; a subsequent N=4 run gives RESULT=24 at E4.
